// File: rtl/toggle_event_scheduler.sv
// Source-side scheduler: latches event pulses, grants them round-robin onto a single
// toggle-handshake CDC channel and waits for the synchronized ack parity before the next grant.
module toggle_event_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] event_in_i,
    input  logic              clear_overflow_i,
    input  logic              ack_toggle_i,
    output logic [NUM_CH-1:0] pending_o,
    output logic [NUM_CH-1:0] overflow_o,
    output logic [CH_W-1:0]   ch_id_o,
    output logic              req_toggle_o,
    output logic              busy_o,
    output logic              done_pulse_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [NUM_CH-1:0] grant_vec;
    logic [NUM_CH-1:0] coalesce_vec;
    logic [CH_W-1:0]   ch_id_q, ch_id_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   sel_idx;
    logic              sel_valid;
    logic              req_q, req_d;
    logic              ack_meta_q, ack_sync_q;
    logic              grant_fire;
    logic              done;

    // Scan downward so the closest set bit after rr_ptr is the last (winning) assignment.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pending_q[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = CH_W'(idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
            assign grant_vec[gi] = grant_fire && (sel_idx == CH_W'(gi));
        end
    endgenerate

    // An event landing on the channel being granted re-arms it instead of coalescing.
    assign coalesce_vec = event_in_i & pending_q & ~grant_vec;
    assign pending_d    = (pending_q & ~grant_vec) | event_in_i;
    assign overflow_d   = clear_overflow_i ? coalesce_vec : (overflow_q | coalesce_vec);

    always_comb begin
        state_d    = state_q;
        ch_id_d    = ch_id_q;
        rr_ptr_d   = rr_ptr_q;
        req_d      = req_q;
        grant_fire = 1'b0;
        done       = 1'b0;
        if (enable_i) begin
            case (state_q)
                S_IDLE: begin
                    if (sel_valid) begin
                        grant_fire = 1'b1;
                        ch_id_d    = sel_idx;
                        rr_ptr_d   = sel_idx;
                        state_d    = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    req_d   = ~req_q;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (ack_sync_q == req_q) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_id_q    <= '0;
            rr_ptr_q   <= CH_W'(NUM_CH - 1);
            req_q      <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_id_q  <= ch_id_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
            if (enable_i) begin
                ack_meta_q <= ack_toggle_i;
                ack_sync_q <= ack_meta_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending_o    = pending_q;
    assign overflow_o   = overflow_q;
    assign ch_id_o      = ch_id_q;
    assign req_toggle_o = req_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_pulse_o = done;

endmodule

// File: tb/tb_toggle_event_scheduler.sv
// Bench for toggle_event_scheduler: directed scenarios plus random traffic, every cycle
// compared against a transfer-level reference model.
module tb_toggle_event_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable_i;
    logic [NUM_CH-1:0] event_in_i;
    logic              clear_overflow_i;
    logic              ack_toggle_i;
    logic [NUM_CH-1:0] pending_o;
    logic [NUM_CH-1:0] overflow_o;
    logic [CH_W-1:0]   ch_id_o;
    logic              req_toggle_o;
    logic              busy_o;
    logic              done_pulse_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: transfer phase 0=idle, 1=launch, 2=wait; ack seen through a 2-deep history.
    logic [NUM_CH-1:0] m_pend, m_ovf;
    int                m_ch, m_last, m_phase;
    logic              m_req;
    logic [1:0]        m_ack_hist;

    toggle_event_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_i         (enable_i),
        .event_in_i       (event_in_i),
        .clear_overflow_i (clear_overflow_i),
        .ack_toggle_i     (ack_toggle_i),
        .pending_o        (pending_o),
        .overflow_o       (overflow_o),
        .ch_id_o          (ch_id_o),
        .req_toggle_o     (req_toggle_o),
        .busy_o           (busy_o),
        .done_pulse_o     (done_pulse_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_pend = '0; m_ovf = '0; m_ch = 0; m_last = NUM_CH - 1;
        m_phase = 0; m_req = 1'b0; m_ack_hist = 2'b00;
    endtask

    function automatic logic model_done();
        return !rst && enable_i && m_phase == 2 && m_ack_hist[1] == m_req;
    endfunction

    task automatic model_step();
        logic [NUM_CH-1:0] gnt, coal;
        int sel;
        gnt = '0;
        sel = -1;
        if (enable_i && m_phase == 0)
            for (int k = 1; k <= NUM_CH; k++)
                if (sel < 0 && m_pend[(m_last + k) % NUM_CH]) sel = (m_last + k) % NUM_CH;
        if (sel >= 0) gnt[sel] = 1'b1;
        coal   = event_in_i & m_pend & ~gnt;
        m_ovf  = clear_overflow_i ? coal : (m_ovf | coal);
        m_pend = (m_pend & ~gnt) | event_in_i;
        if (enable_i) begin
            if (m_phase == 0 && sel >= 0) begin
                m_ch = sel; m_last = sel; m_phase = 1;
            end else if (m_phase == 1) begin
                m_req = ~m_req; m_phase = 2;
            end else if (m_phase == 2 && m_ack_hist[1] == m_req) begin
                m_phase = 0;
            end
            m_ack_hist = {m_ack_hist[0], ack_toggle_i};
        end
    endtask

    task automatic compare_all();
        check("pending",  32'(pending_o),    32'(m_pend));
        check("overflow", 32'(overflow_o),   32'(m_ovf));
        check("ch_id",    32'(ch_id_o),      32'(m_ch));
        check("req",      32'(req_toggle_o), 32'(m_req));
        check("busy",     32'(busy_o),       32'(m_phase != 0));
        check("done",     32'(done_pulse_o), 32'(model_done()));
        if (done_pulse_o) $display("xfer done ch=%0d req=%0b t=%0t", ch_id_o, req_toggle_o, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; enable_i = 1'b1; event_in_i = '0; clear_overflow_i = 1'b0; ack_toggle_i = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_pulse_o && n < 40) begin
            ack_toggle_i = req_toggle_o;
            tick();
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic req_dly[$];
    int   order[$];

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_busy",    32'(busy_o),    32'd0);

        // Single event latency
        event_in_i = 4'b0100; tick(); event_in_i = '0;
        check("se_pending", 32'(pending_o), 32'h4);
        tick();
        check("se_ch_id", 32'(ch_id_o), 32'd2);
        check("se_busy",  32'(busy_o),  32'd1);
        tick();
        check("se_req", 32'(req_toggle_o), 32'd1);
        ack_toggle_i = 1'b1;
        tick();
        check("se_done_early", 32'(done_pulse_o), 32'd0);
        tick();
        check("se_done", 32'(done_pulse_o), 32'd1);
        tick();
        check("se_busy_end", 32'(busy_o), 32'd0);
        check("se_pend_end", 32'(pending_o), 32'd0);

        // Round-robin with a 5-cycle ack echo
        do_reset();
        req_dly.delete(); order.delete();
        event_in_i = 4'b1111; tick(); event_in_i = '0;
        for (int c = 0; c < 80; c++) begin
            req_dly.push_back(req_toggle_o);
            if (req_dly.size() > 5) ack_toggle_i = req_dly.pop_front();
            tick();
            if (done_pulse_o) order.push_back(int'(ch_id_o));
        end
        check("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(i));
        check("rr_req_end", 32'(req_toggle_o), 32'd0);

        // Fairness: last grant ch1, then pending 0011 goes to ch0
        do_reset();
        event_in_i = 4'b0010; tick(); event_in_i = '0;
        wait_done("fair1");
        tick();
        event_in_i = 4'b0011; tick(); event_in_i = '0;
        tick();
        check("fair_ch", 32'(ch_id_o), 32'd0);
        wait_done("fair2");
        tick();

        // Coalescing / overflow with ack held
        do_reset();
        event_in_i = 4'b1000; tick(); event_in_i = '0; tick();
        event_in_i = 4'b1000; tick(); event_in_i = '0; tick();
        event_in_i = 4'b1000; tick(); event_in_i = '0;
        check("ovf_set",  32'(overflow_o), 32'h8);
        check("ovf_pend", 32'(pending_o),  32'h8);
        event_in_i = 4'b1000; clear_overflow_i = 1'b1; tick();
        event_in_i = '0; clear_overflow_i = 1'b0;
        check("ovf_clr_race", 32'(overflow_o), 32'h8);
        ack_toggle_i = 1'b1;
        wait_done("ovf");
        tick();
        event_in_i = 4'b1000; tick(); event_in_i = '0;
        check("rearm_pend", 32'(pending_o),  32'h8);
        check("rearm_ovf",  32'(overflow_o), 32'h8);
        check("rearm_ch",   32'(ch_id_o),    32'd3);
        tick();

        // Enable gating in WAIT
        enable_i = 1'b0; ack_toggle_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            event_in_i = (c == 1) ? 4'b0001 : 4'b0000;
            tick();
            check("en_done", 32'(done_pulse_o), 32'd0);
            check("en_busy", 32'(busy_o),       32'd1);
        end
        check("en_pend", 32'(pending_o), 32'h9);
        enable_i = 1'b1;
        tick();
        check("en_done_1", 32'(done_pulse_o), 32'd0);
        tick();
        check("en_done_2", 32'(done_pulse_o), 32'd1);

        // Asynchronous reset mid-transfer
        do_reset();
        event_in_i = 4'b0100; tick(); event_in_i = '0; tick(); tick(); tick();
        check("mid_req", 32'(req_toggle_o), 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst_req",  32'(req_toggle_o), 32'd0);
        check("arst_ch",   32'(ch_id_o),      32'd0);
        check("arst_busy", 32'(busy_o),       32'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("arst_idle", 32'(busy_o), 32'd0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_CH; i++) event_in_i[i] = ($urandom_range(0, 7) == 0);
            clear_overflow_i = ($urandom_range(0, 9) == 0);
            enable_i         = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) ack_toggle_i = req_toggle_o;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_event_scheduler.md
Name: toggle_event_scheduler

Overview:
- Source-domain controller that shares one toggle-based CDC channel among NUM_CH event requesters.
- Latches single-cycle events as pending bits and grants them round-robin.
- For each grant, presents a bundled channel id, flips a request toggle, then waits for the destination's ack toggle (asynchronous input, synchronized internally) before issuing the next grant.
- Sits in front of a destination-side toggle receiver that decodes req_toggle and ch_id and returns ack_toggle.

Parameters:
- NUM_CH, 4, number of event requesters (2..16).
- CH_W, 2, width of ch_id; must satisfy 2^CH_W >= NUM_CH.

Ports:
- clk  input  1  source-domain clock.
- rst  input  1  reset; asynchronous, active-high.
- enable  input  1  clock enable for the FSM, ack synchronizer and round-robin pointer.
- event_in  input  NUM_CH  single-cycle event pulses, one per requester.
- clear_overflow  input  1  synchronous clear of all overflow bits.
- ack_toggle  input  1  destination ack toggle; asynchronous to clk.
- pending  output  NUM_CH  latched, not-yet-granted events.
- overflow  output  NUM_CH  sticky flag: an event was coalesced into an already-pending bit.
- ch_id  output  CH_W  id of the in-flight channel; stable from one cycle before the req_toggle flip until the ack is seen.
- req_toggle  output  1  request toggle; flips once per transfer.
- busy  output  1  high in LAUNCH and WAIT.
- done_pulse  output  1  one-cycle pulse when the ack for the current transfer is seen.

Behaviour:
- Reset values (asynchronous): pending=0, overflow=0, ch_id=0, req_toggle=0, busy=0, done_pulse=0, FSM=IDLE, rr pointer=NUM_CH-1, ack sync flops=0.
- Event capture: not gated by enable, so no event is lost.
  - event_in[i]=1 sets pending[i] next cycle.
  - If pending[i] is already 1 and not being granted that cycle, overflow[i] is set.
  - If an event for channel i arrives in the same cycle channel i is granted, pending[i] stays 1 and overflow[i] is not set (new event re-arms the channel).
- Overflow clear: clear_overflow zeroes overflow. A set condition in the same cycle wins over the clear.
- Ack synchronizer: two flops on ack_toggle, both advancing only when enable=1, producing ack_sync.
- FSM (advances only when enable=1):
  - IDLE: if pending != 0, select the first set bit scanning upward from rr_ptr+1 modulo NUM_CH. Register ch_id=sel, rr_ptr=sel, clear pending[sel], set busy, go to LAUNCH.
  - LAUNCH: req_toggle <= ~req_toggle, go to WAIT. This gives one cycle of ch_id setup before the toggle flips.
  - WAIT: when ack_sync == req_toggle, pulse done_pulse for one cycle, clear busy, go to IDLE.
  - The next grant can occur in the cycle after done_pulse.
- Latency:
  - event_in at cycle 0 gives pending at cycle 1, the grant decision in cycle 1, ch_id/busy valid at cycle 2, and the req_toggle flip at cycle 3.
  - Minimum done_pulse comes 2 clk edges after ack_toggle changes.
- Ordering: round-robin is fair; each channel waits at most NUM_CH-1 grants. ch_id never changes while busy=1.
- enable=0: FSM, synchronizer and rr_ptr hold. All outputs hold, and done_pulse is forced 0. Event capture and overflow continue.
- Reset mid-transfer: everything returns to reset values and the transfer is abandoned. The destination must be reset in the same reset event so the toggle parity stays matched.
- ack_toggle changing while not in WAIT is a protocol error. It needs no detection; the parity compare re-aligns naturally.

Test Plan:
- Single event: after reset, pulse event_in=4'b0100 at cycle 0 → pending=4'b0100 at cycle 1; ch_id=2 and busy=1 at cycle 2; req_toggle 0→1 at cycle 3. Drive ack_toggle=1 → done_pulse 2 cycles later, busy=0, pending=0.
- Round-robin: pulse event_in=4'b1111 once, model ack with a 5-cycle echo of req_toggle → ch_id sequence 0,1,2,3; exactly 4 done_pulses; req_toggle ends at 0.
- Fairness after a grant: rr_ptr=1 (last grant ch 1), pending=4'b0011 → next grant is ch 0 (wrap), not ch 1.
- Coalescing and overflow:
  - Hold the ack, pulse event_in[3] twice while pending[3]=1 → overflow=4'b1000, pending[3] stays 1.
  - clear_overflow in the same cycle as a new overflow event → overflow stays 4'b1000.
  - Event on ch 3 in its own grant cycle → pending[3] re-set, overflow unchanged.
- enable gating: drop enable in WAIT while ack_toggle flips → no done_pulse, outputs frozen. Event pulses still set pending. Raise enable → done_pulse 2 cycles later.
- Reset mid-transfer: assert rst in WAIT with req_toggle=1, ch_id=2 → all outputs 0 immediately (asynchronous). After release with pending empty, the FSM stays IDLE.
